// File: rtl/pkt_stream_demux_pkg.sv
// pkt_stream_demux_pkg: state encoding and select check shared by the packet demux
package pkt_stream_demux_pkg;

    typedef enum logic [1:0] {IDLE, PKT, DROP} pkt_demux_state_e;

    function automatic logic sel_legal(input int unsigned sel, input int unsigned num_outputs);
        return sel < num_outputs;
    endfunction

endpackage

// File: rtl/pkt_stream_demux_fanout.sv
// pkt_stream_demux_fanout: routes one input word to the selected lane, all other lanes zero
module pkt_stream_demux_fanout #(
    parameter int NUM_OUTPUTS     = 4,
    parameter int NUM_LOG_OUTPUTS = $clog2(NUM_OUTPUTS),
    parameter int INPUT_WIDTH     = 1
) (
    input  logic                                    en,
    input  logic [NUM_LOG_OUTPUTS-1:0]              input_sel,
    input  logic [INPUT_WIDTH-1:0]                  data_input,
    output logic [NUM_OUTPUTS-1:0][INPUT_WIDTH-1:0] data_output
);

    always_comb
        for (int i = 0; i < NUM_OUTPUTS; i++)
            data_output[i] = (en && input_sel == NUM_LOG_OUTPUTS'(i)) ? data_input : '0;

endmodule

// File: rtl/pkt_stream_demux.sv
// pkt_stream_demux: packet-aware val/rdy demux with a 1-deep output register and drop counting
module pkt_stream_demux
    import pkt_stream_demux_pkg::*;
#(
    parameter int NUM_OUTPUTS     = 4,
    parameter int NUM_LOG_OUTPUTS = $clog2(NUM_OUTPUTS),
    parameter int DATA_W          = 512,
    parameter int CNT_W           = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               src_demux_val,
    input  logic [DATA_W-1:0]                  src_demux_data,
    input  logic                               src_demux_last,
    input  logic [NUM_LOG_OUTPUTS-1:0]         src_demux_sel,
    output logic                               demux_src_rdy,
    output logic [NUM_OUTPUTS-1:0]             demux_dst_val,
    output logic [NUM_OUTPUTS-1:0][DATA_W-1:0] demux_dst_data,
    output logic [NUM_OUTPUTS-1:0]             demux_dst_last,
    input  logic [NUM_OUTPUTS-1:0]             dst_demux_rdy,
    output logic [CNT_W-1:0]                   drop_pkt_cnt
);

    pkt_demux_state_e                      state, state_next;
    logic [NUM_LOG_OUTPUTS-1:0]            cur_sel, beat_sel, out_sel;
    logic                                  out_full, out_last, out_done, legal;
    logic                                  accept, load, drop_inc;
    logic [DATA_W-1:0]                     out_data;
    logic [NUM_OUTPUTS-1:0][DATA_W:0]      lanes;

    assign beat_sel = state == PKT ? cur_sel : src_demux_sel;
    assign legal    = sel_legal(32'(beat_sel), NUM_OUTPUTS);
    assign out_done = out_full && dst_demux_rdy[out_sel];

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_next;

    always_comb
        state_next = !accept ? state : src_demux_last ? IDLE : state == IDLE ? (legal ? PKT : DROP) : state;

    // Dropped beats never touch the output register, so rdy ignores its occupancy while dropping
    always_comb begin
        demux_src_rdy = state == DROP || (state == IDLE && !legal) || !out_full || out_done;
        accept        = src_demux_val && demux_src_rdy;
        load          = accept && state != DROP && legal;
        drop_inc      = accept && src_demux_last && (state == DROP || (state == IDLE && !legal));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_full     <= 1'b0;
            out_sel      <= '0;
            out_data     <= '0;
            out_last     <= 1'b0;
            cur_sel      <= '0;
            drop_pkt_cnt <= '0;
        end else begin
            if (load) begin
                out_full <= 1'b1;
                out_sel  <= beat_sel;
                out_data <= src_demux_data;
                out_last <= src_demux_last;
            end else if (out_done) begin
                out_full <= 1'b0;
            end
            if (accept && state == IDLE)
                cur_sel <= beat_sel;
            if (drop_inc && !(&drop_pkt_cnt))
                drop_pkt_cnt <= drop_pkt_cnt + CNT_W'(1);
        end
    end

    pkt_stream_demux_fanout #(
        .NUM_OUTPUTS    (NUM_OUTPUTS),
        .NUM_LOG_OUTPUTS(NUM_LOG_OUTPUTS),
        .INPUT_WIDTH    (DATA_W + 1)
    ) u_fanout (
        .en         (out_full),
        .input_sel  (out_sel),
        .data_input ({out_last, out_data}),
        .data_output(lanes)
    );

    always_comb
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            demux_dst_val[i]  = out_full && out_sel == NUM_LOG_OUTPUTS'(i);
            demux_dst_last[i] = lanes[i][DATA_W];
            demux_dst_data[i] = lanes[i][DATA_W-1:0];
        end

endmodule

// File: tb/tb_pkt_stream_demux.sv
// tb_pkt_stream_demux: directed and random checks of two demux instances (4 and 3 outputs) against a packet-level model
module tb_pkt_stream_demux;

    localparam int DW = 32;

    logic            clk  = 1'b0;
    logic            rst  = 1'b1;
    logic            val  = 1'b0;
    logic            last = 1'b0;
    logic [DW-1:0]   data = '0;
    logic [1:0]      sel  = '0;
    logic [3:0]      drdy = '1;

    logic [3:0]          v0, l0;
    logic [3:0][DW-1:0]  d0;
    logic                r0;
    logic [31:0]         c0;
    logic [2:0]          v1, l1;
    logic [2:0][DW-1:0]  d1;
    logic                r1;
    logic [1:0]          c1;

    always #5 clk = ~clk;

    pkt_stream_demux #(.NUM_OUTPUTS(4), .DATA_W(DW), .CNT_W(32)) dut0 (
        .clk(clk), .rst(rst), .src_demux_val(val), .src_demux_data(data), .src_demux_last(last),
        .src_demux_sel(sel), .demux_src_rdy(r0), .demux_dst_val(v0), .demux_dst_data(d0),
        .demux_dst_last(l0), .dst_demux_rdy(drdy), .drop_pkt_cnt(c0)
    );

    pkt_stream_demux #(.NUM_OUTPUTS(3), .DATA_W(DW), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .src_demux_val(val), .src_demux_data(data), .src_demux_last(last),
        .src_demux_sel(sel), .demux_src_rdy(r1), .demux_dst_val(v1), .demux_dst_data(d1),
        .demux_dst_last(l1), .dst_demux_rdy(drdy[2:0]), .drop_pkt_cnt(c1)
    );

    logic [3:0]          o_val  [2];
    logic [3:0]          o_last [2];
    logic [3:0][DW-1:0]  o_data [2];
    logic                o_rdy  [2];
    longint              o_cnt  [2];

    always_comb begin
        o_val[0]  = v0;
        o_val[1]  = {1'b0, v1};
        o_last[0] = l0;
        o_last[1] = {1'b0, l1};
        o_data[0] = d0;
        o_data[1] = {{DW{1'b0}}, d1};
        o_rdy[0]  = r0;
        o_rdy[1]  = r1;
        o_cnt[0]  = longint'(c0);
        o_cnt[1]  = longint'(c1);
    end

    // Model: cur = destination of the open packet (-1 none, -2 dropping); p* = the one beat awaiting its consumer
    int                  n    [2] = '{4, 3};
    longint              cmax [2] = '{64'hFFFF_FFFF, 3};
    int                  cur  [2];
    bit                  pv   [2];
    int                  pl   [2];
    logic [DW-1:0]       pd   [2];
    bit                  plast[2];
    longint              drops[2];
    bit                  e_rdy[2], e_done[2], e_drop[2], acc[2];
    logic [3:0]          e_val [2];
    logic [3:0]          e_last[2];
    logic [3:0][DW-1:0]  e_data[2];
    int                  checks = 0;
    int                  failures = 0;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            cur[d]   = -1;
            pv[d]    = 1'b0;
            pl[d]    = 0;
            drops[d] = 0;
        end
    endtask

    task automatic predict();
        for (int d = 0; d < 2; d++) begin
            e_val[d]  = '0;
            e_last[d] = '0;
            e_data[d] = '0;
            if (pv[d]) begin
                e_val[d][pl[d]]  = 1'b1;
                e_last[d][pl[d]] = plast[d];
                e_data[d][pl[d]] = pd[d];
            end
            e_done[d] = pv[d] && drdy[pl[d]];
            e_drop[d] = cur[d] == -2 || (cur[d] == -1 && int'(sel) >= n[d]);
            e_rdy[d]  = e_drop[d] || !pv[d] || e_done[d];
            acc[d]    = val && e_rdy[d];
        end
    endtask

    task automatic step();
        for (int d = 0; d < 2; d++) begin
            int lane = cur[d] >= 0 ? cur[d] : int'(sel);
            if (e_done[d]) pv[d] = 1'b0;
            if (acc[d]) begin
                if (e_drop[d]) begin
                    if (last) begin
                        drops[d] = drops[d] < cmax[d] ? drops[d] + 1 : drops[d];
                        cur[d]   = -1;
                    end else begin
                        cur[d] = -2;
                    end
                end else begin
                    pv[d]    = 1'b1;
                    pl[d]    = lane;
                    pd[d]    = data;
                    plast[d] = last;
                    cur[d]   = last ? -1 : lane;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] dt, input logic l, input int s, input logic [3:0] r);
        val  = v;
        data = dt;
        last = l;
        sel  = 2'(s);
        drdy = r;
        #1 predict();
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        val  = 1'b0;
        last = 1'b0;
        data = '0;
        sel  = '0;
        drdy = '1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1 predict();
    endtask

    task automatic test_reset();
        do_reset();
        for (int d = 0; d < 2; d++) begin
            checks++; if (o_rdy[d] !== 1'b1) begin failures++; $display("FAIL reset_rdy dut%0d got=%0b exp=1", d, o_rdy[d]); end
            checks++; if (o_val[d] !== 4'b0) begin failures++; $display("FAIL reset_val dut%0d got=%0b exp=0", d, o_val[d]); end
            checks++; if (o_data[d] !== '0 || o_last[d] !== 4'b0) begin failures++; $display("FAIL reset_lanes dut%0d got=%0h/%0b exp=0", d, o_data[d], o_last[d]); end
            checks++; if (o_cnt[d] !== 0) begin failures++; $display("FAIL reset_cnt dut%0d got=%0d exp=0", d, o_cnt[d]); end
        end
    endtask

    task automatic test_lane2_packet(input int later_sel);
        logic [DW-1:0] dat [3];
        do_reset();
        for (int k = 0; k < 3; k++) dat[k] = $urandom;
        for (int k = 0; k < 4; k++) begin
            if (k < 3) drive(1'b1, dat[k], k == 2, k == 0 ? 2 : later_sel, 4'hF);
            else drive(1'b0, '0, 1'b0, 0, 4'hF);
            checks++; if (r0 !== 1'b1) begin failures++; $display("FAIL pkt_rdy sel%0d beat%0d got=%0b exp=1", later_sel, k, r0); end
            checks++; if (v0 !== (k == 0 ? 4'b0000 : 4'b0100)) begin failures++; $display("FAIL pkt_val sel%0d beat%0d got=%0b", later_sel, k, v0); end
            if (k > 0) begin
                checks++; if (d0[2] !== dat[k-1]) begin failures++; $display("FAIL pkt_data sel%0d beat%0d got=%0h exp=%0h", later_sel, k, d0[2], dat[k-1]); end
                checks++; if ({d0[3], d0[1], d0[0]} !== '0) begin failures++; $display("FAIL pkt_idle_lanes sel%0d beat%0d got nonzero", later_sel, k); end
                checks++; if (l0 !== (k == 3 ? 4'b0100 : 4'b0000)) begin failures++; $display("FAIL pkt_last sel%0d beat%0d got=%0b", later_sel, k, l0); end
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        int            sels [4] = '{0, 1, 3, 0};
        logic [DW-1:0] dat  [4];
        do_reset();
        for (int k = 0; k < 4; k++) dat[k] = $urandom;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) drive(1'b1, dat[k], 1'b1, sels[k], 4'hF);
            else drive(1'b0, '0, 1'b0, 0, 4'hF);
            checks++; if (r0 !== 1'b1) begin failures++; $display("FAIL b2b_rdy cycle%0d got=%0b exp=1", k, r0); end
            if (k > 0) begin
                checks++; if (v0 !== 4'(1 << sels[k-1])) begin failures++; $display("FAIL b2b_val cycle%0d got=%0b exp_lane=%0d", k, v0, sels[k-1]); end
                checks++; if (d0[sels[k-1]] !== dat[k-1]) begin failures++; $display("FAIL b2b_data cycle%0d got=%0h exp=%0h", k, d0[sels[k-1]], dat[k-1]); end
                checks++; if (l0 !== 4'(1 << sels[k-1])) begin failures++; $display("FAIL b2b_last cycle%0d got=%0b", k, l0); end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] sent [4];
        logic [DW-1:0] got  [$];
        logic [DW-1:0] held = '0;
        logic [3:0]    r;
        int            bi = 0;
        do_reset();
        for (int i = 0; i < 4; i++) sent[i] = $urandom;
        for (int c = 0; c < 40 && got.size() < 4; c++) begin
            r = (c >= 2 && c < 7) ? 4'b1101 : 4'b1111;
            drive(bi < 4, sent[bi < 4 ? bi : 3], bi == 3, bi == 0 ? 1 : int'($urandom_range(0, 3)), r);
            checks++; if (r0 !== e_rdy[0]) begin failures++; $display("FAIL bp_rdy cycle%0d got=%0b exp=%0b", c, r0, e_rdy[0]); end
            if (c == 2) begin
                held = d0[1];
                checks++; if (held !== sent[1]) begin failures++; $display("FAIL bp_held got=%0h exp=%0h", held, sent[1]); end
            end
            if (c >= 2 && c < 7) begin
                checks++; if (r0 !== 1'b0) begin failures++; $display("FAIL bp_stall_rdy cycle%0d got=%0b exp=0", c, r0); end
                checks++; if (v0 !== 4'b0010 || d0[1] !== held) begin failures++; $display("FAIL bp_stable cycle%0d got=%0b/%0h exp=0010/%0h", c, v0, d0[1], held); end
            end
            if (v0[1] && r[1]) got.push_back(d0[1]);
            if (acc[0]) bi++;
            step();
        end
        checks++; if (got.size() != 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", got.size()); end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            checks++; if (got[i] !== sent[i]) begin failures++; $display("FAIL bp_order beat%0d got=%0h exp=%0h", i, got[i], sent[i]); end
        end
    endtask

    task automatic test_drop();
        int            sels [6] = '{3, 3, 3, 3, 1, 2};
        logic [DW-1:0] dat  [6];
        do_reset();
        for (int k = 0; k < 6; k++) dat[k] = $urandom;
        for (int k = 0; k < 8; k++) begin
            if (k < 6) drive(1'b1, dat[k], k == 3 || k == 5, sels[k], 4'hF);
            else drive(1'b0, '0, 1'b0, 0, 4'hF);
            checks++; if (r1 !== 1'b1) begin failures++; $display("FAIL drop_rdy cycle%0d got=%0b exp=1", k, r1); end
            checks++; if (v1 !== ((k == 5 || k == 6) ? 3'b010 : 3'b000)) begin failures++; $display("FAIL drop_val cycle%0d got=%0b", k, v1); end
            checks++; if (c1 !== (k >= 4 ? 2'd1 : 2'd0)) begin failures++; $display("FAIL drop_cnt cycle%0d got=%0d", k, c1); end
            if (k == 5 || k == 6) begin
                checks++; if (d1[1] !== dat[k-1]) begin failures++; $display("FAIL drop_next_data cycle%0d got=%0h exp=%0h", k, d1[1], dat[k-1]); end
                checks++; if (l1 !== (k == 6 ? 3'b010 : 3'b000)) begin failures++; $display("FAIL drop_next_last cycle%0d got=%0b", k, l1); end
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] dn;
        do_reset();
        dn = $urandom;
        drive(1'b1, $urandom, 1'b0, 2, 4'hF);
        step();
        drive(1'b1, $urandom, 1'b0, 2, 4'hF);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        drive(1'b0, '0, 1'b0, 0, 4'hF);
        checks++; if (v0 !== 4'b0 || v1 !== 3'b0) begin failures++; $display("FAIL rstmid_val got=%0b/%0b exp=0", v0, v1); end
        checks++; if (r0 !== 1'b1) begin failures++; $display("FAIL rstmid_rdy got=%0b exp=1", r0); end
        step();
        drive(1'b1, dn, 1'b1, 0, 4'hF);
        step();
        drive(1'b0, '0, 1'b0, 0, 4'hF);
        checks++; if (v0 !== 4'b0001 || l0 !== 4'b0001) begin failures++; $display("FAIL rstmid_fresh_sel got=%0b/%0b exp=0001", v0, l0); end
        checks++; if (d0[0] !== dn) begin failures++; $display("FAIL rstmid_data got=%0h exp=%0h", d0[0], dn); end
        step();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 3) == 0, int'($urandom_range(0, 3)),
                  4'($urandom) | 4'($urandom));
            for (int d = 0; d < 2; d++) begin
                checks++; if (o_rdy[d] !== e_rdy[d]) begin failures++; $display("FAIL rnd_rdy dut%0d cycle%0d got=%0b exp=%0b", d, c, o_rdy[d], e_rdy[d]); end
                checks++; if (o_val[d] !== e_val[d]) begin failures++; $display("FAIL rnd_val dut%0d cycle%0d got=%0b exp=%0b", d, c, o_val[d], e_val[d]); end
                checks++; if (o_last[d] !== e_last[d]) begin failures++; $display("FAIL rnd_last dut%0d cycle%0d got=%0b exp=%0b", d, c, o_last[d], e_last[d]); end
                checks++; if (o_data[d] !== e_data[d]) begin failures++; $display("FAIL rnd_data dut%0d cycle%0d got=%0h exp=%0h", d, c, o_data[d], e_data[d]); end
                checks++; if (o_cnt[d] !== drops[d]) begin failures++; $display("FAIL rnd_cnt dut%0d cycle%0d got=%0d exp=%0d", d, c, o_cnt[d], drops[d]); end
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_lane2_packet(2);
        test_lane2_packet(0);
        test_back_to_back();
        test_backpressure();
        test_drop();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
